// File: rtl/sram_like_arbiter_pkg.sv
// Shared constants for the SRAM-like two-master arbiter.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
//
// Holds the master source ids stored in the order FIFO, the transfer size
// encodings of the SRAM-like bus, and the grant FSM state encodings.
package sram_like_arbiter_pkg;

  // Source id carried through the outstanding-order FIFO.
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  // SRAM-like transfer size encodings.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Grant FSM states: free arbitration, or grant pinned to one master.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOCK_I = 2'd1;
  localparam logic [1:0] ST_LOCK_D = 2'd2;

  // Lock state that pins the grant to the given source.
  function automatic logic [1:0] lock_state(input logic src);
    return (src == SRC_DATA) ? ST_LOCK_D : ST_LOCK_I;
  endfunction

endpackage

// File: rtl/sram_arb_otd_fifo.sv
// Order FIFO of 1-bit source ids for accepted-but-unanswered transactions.
// Latency: a pushed id is visible at head the cycle after the push.
// Backpressure: full/empty flags; push while full and pop while empty are ignored.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   push, din          enqueue one source id
//   pop                dequeue the head id
//   full, empty, head  status flags and the oldest stored id
module sram_arb_otd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] store;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = store[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: it is only read when count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-like arbiter with in-order return routing.
// Latency: zero added; req/addr_ok/data_ok pass combinationally, data_ok earliest at t+1.
// Backpressure: grant locks while mem_addr_ok is low; mem_req is withheld while the order FIFO is full.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   inst_sram_*             instruction-fetch master (req/wr/size/wstrb/addr/wdata in,
//                           addr_ok/data_ok/rdata out)
//   data_sram_*             data-access master, same set
//   mem_*                   downstream SRAM-like port toward the AXI bridge
//   otd_err                 sticky: mem_data_ok seen with nothing outstanding
//
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration in IDLE;
// otherwise the data master has fixed priority over the instruction master.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OTD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        otd_err
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       idle_gnt;
  logic       gnt;
  logic       gnt_req;
  logic       accept;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_head;
  logic       ret_vld;

`ifdef SRAM_ARB_RR_EN
  logic last_gnt;

  // On contention the master that did not win the last handshake goes first.
  always_comb begin
    idle_gnt = SRC_INST;
    if (inst_sram_req && data_sram_req) idle_gnt = ~last_gnt;
    else if (data_sram_req)             idle_gnt = SRC_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset)       last_gnt <= SRC_INST;
    else if (accept) last_gnt <= gnt;
  end
`else
  // Data master has fixed priority; with no request the pick is irrelevant.
  always_comb begin
    idle_gnt = SRC_INST;
    if (data_sram_req) idle_gnt = SRC_DATA;
  end
`endif

  always_comb begin
    case (state)
      ST_LOCK_I: gnt = SRC_INST;
      ST_LOCK_D: gnt = SRC_DATA;
      default:   gnt = idle_gnt;
    endcase
  end

  assign gnt_req = (gnt == SRC_DATA) ? data_sram_req : inst_sram_req;
  assign mem_req = gnt_req & ~fifo_full & ~reset;
  assign accept  = mem_req & mem_addr_ok;

  // Lock on an unanswered request so the downstream payload stays stable.
  // A locked master dropping req (pipeline cancel) releases the lock; a full
  // FIFO keeps an existing lock because the request is merely withheld.
  always_comb begin
    state_nxt = ST_IDLE;
    if (state == ST_IDLE) begin
      if (mem_req && !mem_addr_ok) state_nxt = lock_state(gnt);
    end else if (gnt_req && !accept) begin
      state_nxt = state;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  assign mem_wr    = (gnt == SRC_DATA) ? data_sram_wr    : inst_sram_wr;
  assign mem_size  = (gnt == SRC_DATA) ? data_sram_size  : inst_sram_size;
  assign mem_wstrb = (gnt == SRC_DATA) ? data_sram_wstrb : inst_sram_wstrb;
  assign mem_addr  = (gnt == SRC_DATA) ? data_sram_addr  : inst_sram_addr;
  assign mem_wdata = (gnt == SRC_DATA) ? data_sram_wdata : inst_sram_wdata;

  assign inst_sram_addr_ok = accept & (gnt == SRC_INST);
  assign data_sram_addr_ok = accept & (gnt == SRC_DATA);

  sram_arb_otd_fifo #(
    .DEPTH (OTD_DEPTH)
  ) u_otd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (gnt),
    .pop   (ret_vld),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // FIFO status is pre-reset state during a reset cycle, hence the gate.
  assign ret_vld           = mem_data_ok & ~fifo_empty & ~reset;
  assign inst_sram_data_ok = ret_vld & (fifo_head == SRC_INST);
  assign data_sram_data_ok = ret_vld & (fifo_head == SRC_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset)                           otd_err <= 1'b0;
    else if (mem_data_ok && fifo_empty)  otd_err <= 1'b1;
  end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-master to one-slave arbiter for the SRAM-like bus. It sits between the CPU core's instruction-fetch port (inst_sram_*) and data-access port (data_sram_*) and a single downstream SRAM-like port (mem_*), which feeds the AXI bridge. It serialises address handshakes between the two masters and tracks outstanding transactions in order, so each data_ok/rdata return is routed to the master that issued it.

## Interface
- OTD_DEPTH, 4: maximum accepted-but-unanswered transactions; power of two, 2..16.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- inst_sram_req / inst_sram_wr  in  1 / 1  instruction master request, write flag.
- inst_sram_size  in  2  transfer size: 0 = byte, 1 = half, 2 = word.
- inst_sram_wstrb  in  4  byte strobes.
- inst_sram_addr / inst_sram_wdata  in  32 / 32  address, write data.
- inst_sram_addr_ok / inst_sram_data_ok  out  1 / 1  address accepted, data returned.
- inst_sram_rdata  out  32  read data.
- data_sram_*: identical set for the data master.
- mem_req / mem_wr  out  1 / 1  downstream request, write flag.
- mem_size / mem_wstrb  out  2 / 4  downstream size, strobes.
- mem_addr / mem_wdata  out  32 / 32  downstream address, write data.
- mem_addr_ok / mem_data_ok  in  1 / 1  downstream handshakes.
- mem_rdata  in  32  downstream read data.
- otd_err  out  1  sticky: mem_data_ok arrived with no outstanding transaction.

## Operation
- Grant FSM states: IDLE, LOCK_I, LOCK_D.
  - IDLE: combinational grant among the requesting masters. Default policy: data master has fixed priority.
  - Granted master's req, wr, size, wstrb, addr and wdata are muxed onto mem_*.
  - mem_req = granted req & ~fifo_full.
- Grant lock:
  - If mem_req=1 and mem_addr_ok=0, the FSM moves to LOCK_x.
  - In LOCK_x the grant stays on x regardless of the other master's req, so the downstream request stays stable.
  - On mem_addr_ok the FSM returns to IDLE.
  - If x drops req while in LOCK_x (cancel), the FSM returns to IDLE next cycle. This is tolerated and is not an error.
- Address handshake: x_addr_ok = mem_addr_ok & granted==x & mem_req. The non-granted master's addr_ok is 0.
- Order FIFO: 1-bit source id (0 = inst, 1 = data).
  - Push on mem_req & mem_addr_ok.
  - Pop on mem_data_ok when not empty.
  - Push and pop in the same cycle are allowed; count stays unchanged.
- Return routing:
  - x_data_ok = mem_data_ok & ~fifo_empty & head==x.
  - mem_rdata is broadcast to both inst_sram_rdata and data_sram_rdata.
  - Writes also consume a data_ok.
- Full: mem_req is forced to 0 and neither master sees addr_ok. FSM lock is kept if it was already locked.
- Empty with mem_data_ok: both data_ok are 0 and otd_err sets. otd_err clears only on reset.
- Pointer width is log2(OTD_DEPTH) and pointers wrap modulo the depth. Count width is log2(OTD_DEPTH)+1.

## Timing
- Reset values: FSM=IDLE, FIFO empty, otd_err=0.
  - mem_req, every *_addr_ok and every *_data_ok are 0 while reset=1, even if a master requests.
  - mem_addr, mem_wdata and the other mem_* payload are don't-care when mem_req=0.
- Zero added latency:
  - mem_req follows the master req combinationally in the same cycle.
  - addr_ok and data_ok pass through combinationally.
- A transaction accepted in cycle t can receive its data_ok in cycle t+1 at the earliest (the pushed id is visible at the head next cycle).
- Reset asserted mid-transaction drops all outstanding ids. Downstream responses after reset are treated as unsolicited and set otd_err. The system guarantees reset covers the downstream side too.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin policy in IDLE.
  - A last-grant register (reset = inst) updates on every mem_addr_ok.
  - On simultaneous requests the master not granted last wins.
- SRAM_ARB_RR_EN undefined: fixed data-over-inst priority and no last-grant register.

## Structure
- Shared package: SRC_INST/SRC_DATA id constants, size encodings (SIZE_B/H/W), and FSM state encodings.
- One sub-module, sram_arb_otd_fifo: synchronous FIFO of width 1 and depth OTD_DEPTH, with full, empty, head, push and pop.
- The arbiter top holds the FSM, the muxing and otd_err.

## Test plan
- Single inst read at 0x1C000000, mem_addr_ok same cycle, mem_data_ok +2 with rdata 0x12345678 → inst_sram_addr_ok=1 at t and inst_sram_data_ok=1 at t+2 with that rdata; data_sram_data_ok stays 0.
- Inst and data both request in the same cycle (data store to 0x1000 with wstrb 0xF):
  - Fixed mode: data granted first and inst next.
  - RR mode (last grant = data): inst granted first.
  - In both modes the data_ok returns route in acceptance order.
- Inst requests and mem_addr_ok is held 0 for 3 cycles while data requests from cycle 1 → mem_addr stays at the inst address throughout the lock; data is granted only after inst's addr_ok.
- OTD_DEPTH=4, four reads accepted with no data_ok → fifth request gives mem_req=0. One mem_data_ok → mem_req reasserts the next cycle.
- mem_data_ok with the FIFO empty → both data_ok=0 and otd_err=1 sticky; reset clears it.
- Inst drops req mid-lock (pipeline cancel) → FSM returns to IDLE and a pending data request is granted the next cycle.
